alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single-cycle integer ALU between two requesters, the main integer pipe (port 0) and the address/branch unit (port 1). Each requester uses a valid/ready handshake. The block arbitrates round-robin and drives the ALU operand and select lines combinationally. It captures the ALU result, together with the requester's tag and source id, in a small in-order result FIFO that drains through its own valid/ready handshake. It sits between decode/issue and writeback in the execute stage.

## Interface
- XLEN, 32: operand/result width
- OPW, 5: ALU operation-select width (encodings from shared `instr_op` defines)
- TAGW, 4: requester tag width
- DEPTH, 2: result FIFO entries, ≥1, any integer (not restricted to power of 2)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accepted this cycle
- req_op1  in  2×XLEN  per-port operand 1
- req_op2  in  2×XLEN  per-port operand 2
- req_sel  in  2×OPW  per-port ALU operation
- req_tag  in  2×TAGW  per-port tag, returned with result
- alu_op1, alu_op2  out  XLEN  operands to ALU
- alu_sel  out  OPW  operation to ALU
- alu_result  in  XLEN  combinational ALU result
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_result  out  XLEN  head result
- out_tag  out  TAGW  head tag
- out_src  out  1  head source port (0/1)
- flush  in  1  synchronous discard of FIFO contents

## Operation
- Priority pointer `prio` (1 bit) names the favoured port; reset value 0.
- grant: if only one port is valid, grant it; if both are valid, grant `prio`; if none, no grant.
- space = (count < DEPTH). No same-cycle pop-then-push bypass: a full FIFO blocks even when out_ready=1.
- req_ready[i] = grant[i] & space & ~flush. At most one bit is ever set.
- alu_op1/op2/sel carry the granted port's fields; all zero when there is no grant.
- Accept (valid & ready on a port) pushes {alu_result, tag, src} at the tail.
- `prio` updates only on an accept that happened while both ports were valid: it becomes the non-granted port. A single-port accept leaves `prio` unchanged.
- Pop when out_valid & out_ready. Push and pop in the same cycle leave count unchanged.
- Head/tail pointers wrap at DEPTH−1 → 0 (modulo DEPTH, not power-of-2 masking).
- flush: count, head and tail are set to 0 next cycle. No accept occurs in a flush cycle. A pop in the same cycle is ignored. `prio` is unaffected.
- ALU result is captured the same cycle it is granted; the ALU is never held across cycles.
- Requesters may change or drop inputs while not accepted; the block keeps no state about pending requests.

## Timing
- Reset values:
  - req_ready=0 during the rst cycle.
  - out_valid=0.
  - out_result/out_tag/out_src=0 (head storage cleared).
  - count=0, `prio`=0.
- Latency: accept in cycle N → out_valid=1 with that result in cycle N+1 if the FIFO was empty.
- Throughput: one accept per cycle while space holds.
- req_ready, alu_* are combinational from req_valid, `prio`, count and flush.
- out_* are registered; they depend only on FIFO state.
- rst mid-operation discards all FIFO entries; no output is produced from pre-reset requests.
- rst has priority over flush; flush has priority over push and pop.

## Structure
- Shared package `alu_pkg`: XLEN/OPW/TAGW defaults and a result-entry typedef {result, tag, src}. Select encodings come from the existing `instr_op` defines.
- Sub-module `result_fifo` (parameterised DEPTH, entry type, flush). The arbiter and `prio` logic stay in the top module.

## Test plan
- Single port: port 0 valid, sel=ADD, op1=5, op2=7, tag=3 → req_ready[0]=1 cycle N. Cycle N+1: out_result=12, out_tag=3, out_src=0.
- Contention: both ports valid for 4 cycles after reset with out_ready=1 → grants 0,1,0,1; out_src order is the same.
- Backpressure with DEPTH=2, out_ready=0, port 1 always valid → two accepts, then req_ready=0. Raising out_ready for one cycle → one pop, then the next accept one cycle later.
- Flush with FIFO holding 2 entries and port 0 valid → no accept that cycle, out_valid=0 next cycle, `prio` unchanged.
- Simultaneous push/pop with count=1 → count remains 1, FIFO order preserved. Run 100 random cycles with DEPTH=3 to cover wrap-around; compare against a scoreboard model.
- Reset mid-traffic: rst asserted with 2 entries queued → out_valid=0 and `prio`=0 next cycle. The first post-reset contention grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, operation encodings and result-entry type
package alu_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_OPW  = 5;
    localparam int DEF_TAGW = 4;

    // Operation encodings shared with decode (instr_op)
    localparam logic [DEF_OPW-1:0] OP_ADD = 5'd0;
    localparam logic [DEF_OPW-1:0] OP_SUB = 5'd1;
    localparam logic [DEF_OPW-1:0] OP_AND = 5'd2;
    localparam logic [DEF_OPW-1:0] OP_OR  = 5'd3;
    localparam logic [DEF_OPW-1:0] OP_XOR = 5'd4;

    typedef struct packed {
        logic [DEF_XLEN-1:0] result;
        logic [DEF_TAGW-1:0] tag;
        logic                src;
    } res_entry_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - in-order result FIFO with modulo-DEPTH pointers and flush
module result_fifo import alu_pkg::*; #(
    parameter int DEPTH = 2,
    parameter type entry_t = res_entry_t,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop_req,
    output logic          out_valid,
    output entry_t        head_data,
    output logic [CW-1:0] count
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-2 depths work
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop    = pop_req & (count_q != '0);
    assign out_valid = (count_q != '0);
    assign head_data = mem_q[head_q];
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = wrap_inc(tail_q);
            end
            if (do_pop) begin
                head_d = wrap_inc(head_q);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push && !flush) begin
                mem_q[tail_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of the integer ALU between two requesters
module alu_arbiter import alu_pkg::*; #(
    parameter int XLEN  = DEF_XLEN,
    parameter int OPW   = DEF_OPW,
    parameter int TAGW  = DEF_TAGW,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*XLEN-1:0] req_op1,
    input  logic [2*XLEN-1:0] req_op2,
    input  logic [2*OPW-1:0]  req_sel,
    input  logic [2*TAGW-1:0] req_tag,
    output logic [XLEN-1:0]   alu_op1,
    output logic [XLEN-1:0]   alu_op2,
    output logic [OPW-1:0]    alu_sel,
    input  logic [XLEN-1:0]   alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAGW-1:0]   out_tag,
    output logic              out_src,
    input  logic              flush
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [TAGW-1:0] tag;
        logic            src;
    } entry_t;

    localparam int CW = $clog2(DEPTH + 1);

    logic          prio_q, prio_d;
    logic [1:0]    grant;
    logic          both;
    logic          gsel;
    logic          space;
    logic          accept;
    logic [CW-1:0] fifo_count;
    entry_t        push_entry;
    entry_t        head_entry;

    always_comb begin
        both       = &req_valid;
        grant      = both ? (prio_q ? 2'b10 : 2'b01) : req_valid;
        gsel       = grant[1];
        // No pop-then-push bypass: a full FIFO refuses even while draining
        space      = (fifo_count < CW'(DEPTH));
        req_ready  = grant & {2{space & ~flush & ~rst}};
        accept     = |req_ready;
        alu_op1    = '0;
        alu_op2    = '0;
        alu_sel    = '0;
        if (|grant) begin
            alu_op1 = gsel ? req_op1[2*XLEN-1:XLEN] : req_op1[XLEN-1:0];
            alu_op2 = gsel ? req_op2[2*XLEN-1:XLEN] : req_op2[XLEN-1:0];
            alu_sel = gsel ? req_sel[2*OPW-1:OPW]   : req_sel[OPW-1:0];
        end
        push_entry.result = alu_result;
        push_entry.tag    = gsel ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
        push_entry.src    = gsel;
        prio_d = prio_q;
        if (accept && both) begin
            prio_d = ~gsel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (accept),
        .push_data (push_entry),
        .pop_req   (out_ready),
        .out_valid (out_valid),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign out_result = head_entry.result;
    assign out_tag    = head_entry.tag;
    assign out_src    = head_entry.src;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector table plus scoreboard run for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sel;
        logic [3:0]  tag;
    } req_t;

    typedef struct {
        logic [1:0]  v;
        int          p0;
        int          p1;
        logic        ordy;
        logic        fl;
        logic [1:0]  erdy;
        logic [31:0] eop1;
        logic        eov;
        logic [31:0] eres;
        logic [3:0]  etag;
        logic        esrc;
    } vec_t;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  t;
        logic        s;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        rst_a, ordy_a, flush_a, ov_a, osrc_a;
    logic [1:0]  valid_a, rdy_a;
    logic [63:0] op1_a, op2_a;
    logic [9:0]  sel_a;
    logic [7:0]  tag_a;
    logic [31:0] aop1_a, aop2_a, ares_a, ores_a;
    logic [4:0]  asel_a;
    logic [3:0]  otag_a;

    logic        rst_b, ordy_b, flush_b, ov_b, osrc_b;
    logic [1:0]  valid_b, rdy_b;
    logic [63:0] op1_b, op2_b;
    logic [9:0]  sel_b;
    logic [7:0]  tag_b;
    logic [31:0] aop1_b, aop2_b, ares_b, ores_b;
    logic [4:0]  asel_b;
    logic [3:0]  otag_b;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] s);
        case (s)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign ares_a = alu_f(aop1_a, aop2_a, asel_a);
    assign ares_b = alu_f(aop1_b, aop2_b, asel_b);

    alu_arbiter #(.DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_ready(rdy_a),
        .req_op1(op1_a), .req_op2(op2_a), .req_sel(sel_a), .req_tag(tag_a),
        .alu_op1(aop1_a), .alu_op2(aop2_a), .alu_sel(asel_a), .alu_result(ares_a),
        .out_valid(ov_a), .out_ready(ordy_a), .out_result(ores_a), .out_tag(otag_a),
        .out_src(osrc_a), .flush(flush_a)
    );

    alu_arbiter #(.DEPTH(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_ready(rdy_b),
        .req_op1(op1_b), .req_op2(op2_b), .req_sel(sel_b), .req_tag(tag_b),
        .alu_op1(aop1_b), .alu_op2(aop2_b), .alu_sel(asel_b), .alu_result(ares_b),
        .out_valid(ov_b), .out_ready(ordy_b), .out_result(ores_b), .out_tag(otag_b),
        .out_src(osrc_b), .flush(flush_b)
    );

    req_t reqs [9];
    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_a(input logic [1:0] v, input req_t r0, input req_t r1,
                           input logic ordy, input logic fl);
        valid_a = v;
        op1_a   = {r1.a, r0.a};
        op2_a   = {r1.b, r0.b};
        sel_a   = {r1.sel, r0.sel};
        tag_a   = {r1.tag, r0.tag};
        ordy_a  = ordy;
        flush_a = fl;
    endtask

    task automatic drive_b(input logic [1:0] v, input req_t r0, input req_t r1,
                           input logic ordy, input logic fl);
        valid_b = v;
        op1_b   = {r1.a, r0.a};
        op2_b   = {r1.b, r0.b};
        sel_b   = {r1.sel, r0.sel};
        tag_b   = {r1.tag, r0.tag};
        ordy_b  = ordy;
        flush_b = fl;
    endtask

    ent_t       q [$];
    ent_t       ent;
    logic       prio_m;
    logic [1:0] g_m, er_m;
    logic       both_m, gs_m;

    initial begin
        reqs[0] = '{32'd5,      32'd7,      OP_ADD, 4'd3};
        reqs[1] = '{32'd20,     32'd8,      OP_SUB, 4'd1};
        reqs[2] = '{32'h0000_00F0, 32'h0000_00FF, OP_XOR, 4'd9};
        reqs[3] = '{32'h0000_FF00, 32'h0000_0F0F, OP_AND, 4'd5};
        reqs[4] = '{32'h0000_FF00, 32'h0000_0F0F, OP_AND, 4'd6};
        reqs[5] = '{32'h0000_FF00, 32'h0000_0F0F, OP_AND, 4'd7};
        reqs[6] = '{32'd1,      32'd2,      OP_ADD, 4'd2};
        reqs[7] = '{32'h0000_FF00, 32'h0000_0F0F, OP_AND, 4'd8};
        reqs[8] = '{32'd0,      32'd0,      OP_ADD, 4'd0};

        //            v     p0 p1 ordy  fl    erdy   eop1          eov   eres          etag  esrc
        vecs[0]  = '{2'b01, 0, 8, 1'b1, 1'b0, 2'b01, 32'd5,        1'b1, 32'd12,       4'd3, 1'b0};
        vecs[1]  = '{2'b00, 8, 8, 1'b1, 1'b0, 2'b00, 32'd0,        1'b0, 32'd0,        4'd0, 1'b0};
        vecs[2]  = '{2'b11, 1, 2, 1'b1, 1'b0, 2'b01, 32'd20,       1'b1, 32'd12,       4'd1, 1'b0};
        vecs[3]  = '{2'b11, 1, 2, 1'b1, 1'b0, 2'b10, 32'h00F0,     1'b1, 32'h000F,     4'd9, 1'b1};
        vecs[4]  = '{2'b11, 1, 2, 1'b1, 1'b0, 2'b01, 32'd20,       1'b1, 32'd12,       4'd1, 1'b0};
        vecs[5]  = '{2'b11, 1, 2, 1'b1, 1'b0, 2'b10, 32'h00F0,     1'b1, 32'h000F,     4'd9, 1'b1};
        vecs[6]  = '{2'b11, 1, 2, 1'b1, 1'b0, 2'b01, 32'd20,       1'b1, 32'd12,       4'd1, 1'b0};
        vecs[7]  = '{2'b00, 8, 8, 1'b1, 1'b0, 2'b00, 32'd0,        1'b0, 32'd0,        4'd0, 1'b0};
        vecs[8]  = '{2'b10, 8, 3, 1'b0, 1'b0, 2'b10, 32'hFF00,     1'b1, 32'h0F00,     4'd5, 1'b1};
        vecs[9]  = '{2'b10, 8, 4, 1'b0, 1'b0, 2'b10, 32'hFF00,     1'b1, 32'h0F00,     4'd5, 1'b1};
        vecs[10] = '{2'b10, 8, 5, 1'b0, 1'b0, 2'b00, 32'hFF00,     1'b1, 32'h0F00,     4'd5, 1'b1};
        vecs[11] = '{2'b10, 8, 5, 1'b1, 1'b0, 2'b00, 32'hFF00,     1'b1, 32'h0F00,     4'd6, 1'b1};
        vecs[12] = '{2'b10, 8, 5, 1'b0, 1'b0, 2'b10, 32'hFF00,     1'b1, 32'h0F00,     4'd6, 1'b1};
        vecs[13] = '{2'b01, 6, 8, 1'b1, 1'b1, 2'b00, 32'd1,        1'b0, 32'd0,        4'd0, 1'b0};
        vecs[14] = '{2'b11, 6, 7, 1'b0, 1'b0, 2'b10, 32'hFF00,     1'b1, 32'h0F00,     4'd8, 1'b1};
        vecs[15] = '{2'b11, 6, 7, 1'b1, 1'b0, 2'b01, 32'd1,        1'b1, 32'd3,        4'd2, 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(2'b11, reqs[1], reqs[2], 1'b0, 1'b0);
        drive_b(2'b00, reqs[8], reqs[8], 1'b0, 1'b0);
        #1;
        chk("rst_ready", {30'd0, rdy_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_out_result", ores_a, 32'd0);
        chk("rst_out_tag", {28'd0, otag_a}, 32'd0);
        chk("rst_out_src", {31'd0, osrc_a}, 32'd0);
        chk("rst_out_valid_b", {31'd0, ov_b}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive_a(vecs[i].v, reqs[vecs[i].p0], reqs[vecs[i].p1], vecs[i].ordy, vecs[i].fl);
            #1;
            chk($sformatf("vec%0d_ready", i), {30'd0, rdy_a}, {30'd0, vecs[i].erdy});
            chk($sformatf("vec%0d_alu_op1", i), aop1_a, vecs[i].eop1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {31'd0, ov_a}, {31'd0, vecs[i].eov});
            if (vecs[i].eov) begin
                chk($sformatf("vec%0d_out_result", i), ores_a, vecs[i].eres);
                chk($sformatf("vec%0d_out_tag", i), {28'd0, otag_a}, {28'd0, vecs[i].etag});
                chk($sformatf("vec%0d_out_src", i), {31'd0, osrc_a}, {31'd0, vecs[i].esrc});
            end
        end

        // Reset with two entries queued and the pointer favouring port 1
        drive_a(2'b10, reqs[8], reqs[3], 1'b0, 1'b0);
        #1;
        chk("pre_rst_ready", {30'd0, rdy_a}, 32'd2);
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        drive_a(2'b11, reqs[1], reqs[2], 1'b0, 1'b0);
        #1;
        chk("midrst_ready", {30'd0, rdy_a}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'd0, ov_a}, 32'd0);
        chk("midrst_out_result", ores_a, 32'd0);
        rst_a = 1'b0;
        drive_a(2'b11, reqs[1], reqs[2], 1'b1, 1'b0);
        #1;
        chk("postrst_grant", {30'd0, rdy_a}, 32'd1);
        @(posedge clk);
        #1;
        chk("postrst_out_valid", {31'd0, ov_a}, 32'd1);
        chk("postrst_out_result", ores_a, 32'd12);
        chk("postrst_out_src", {31'd0, osrc_a}, 32'd0);
        drive_a(2'b00, reqs[8], reqs[8], 1'b1, 1'b0);

        // Push and pop together with one entry held (DEPTH=3 instance)
        drive_b(2'b01, reqs[0], reqs[8], 1'b0, 1'b0);
        #1;
        chk("pp_first_ready", {30'd0, rdy_b}, 32'd1);
        @(posedge clk);
        #1;
        chk("pp_first_tag", {28'd0, otag_b}, 32'd3);
        drive_b(2'b01, reqs[6], reqs[8], 1'b1, 1'b0);
        #1;
        chk("pp_both_ready", {30'd0, rdy_b}, 32'd1);
        @(posedge clk);
        #1;
        chk("pp_out_valid", {31'd0, ov_b}, 32'd1);
        chk("pp_out_result", ores_b, 32'd3);
        chk("pp_out_tag", {28'd0, otag_b}, 32'd2);
        drive_b(2'b00, reqs[8], reqs[8], 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("pp_drained", {31'd0, ov_b}, 32'd0);

        prio_m = 1'b0;
        for (int c = 0; c < 100; c++) begin
            valid_b = {($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0)};
            op1_b   = {$urandom(), $urandom()};
            op2_b   = {$urandom(), $urandom()};
            sel_b   = {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))};
            tag_b   = 8'($urandom());
            ordy_b  = ($urandom_range(0, 2) == 0);
            flush_b = ($urandom_range(0, 15) == 0);
            both_m  = &valid_b;
            g_m     = both_m ? (prio_m ? 2'b10 : 2'b01) : valid_b;
            gs_m    = g_m[1];
            er_m    = g_m & {2{(q.size() < 3) && !flush_b}};
            ent.r   = gs_m ? alu_f(op1_b[63:32], op2_b[63:32], sel_b[9:5])
                           : alu_f(op1_b[31:0], op2_b[31:0], sel_b[4:0]);
            ent.t   = gs_m ? tag_b[7:4] : tag_b[3:0];
            ent.s   = gs_m;
            #1;
            chk("rand_ready", {30'd0, rdy_b}, {30'd0, er_m});
            chk("rand_out_valid", {31'd0, ov_b}, {31'd0, (q.size() != 0)});
            if (q.size() != 0) begin
                chk("rand_out_result", ores_b, q[0].r);
                chk("rand_out_tag", {28'd0, otag_b}, {28'd0, q[0].t});
                chk("rand_out_src", {31'd0, osrc_b}, {31'd0, q[0].s});
            end
            @(posedge clk);
            if (flush_b) begin
                q.delete();
            end else begin
                if (q.size() != 0 && ordy_b) begin
                    void'(q.pop_front());
                end
                if (|er_m) begin
                    q.push_back(ent);
                    if (both_m) begin
                        prio_m = ~gs_m;
                    end
                end
            end
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
